// File: rtl/data_ram.sv
// data_ram: single-port word RAM with clear sequencer, access error flag and optional parity (macro DATA_RAM_PARITY_EN)
//   clk          system clock, all logic on posedge
//   reset        synchronous active-low reset
//   we_i         1 = write, 0 = read (sampled every READY cycle)
//   addr_i       byte address
//   data_i       write data
//   data_o       registered read data, valid the cycle after the access
//   busy_o       clear sequencer running; accesses ignored
//   err_o        previous access was misaligned or out of range
//   parity_err_o previous read hit a parity fault (0 unless DATA_RAM_PARITY_EN)
module data_ram #(
  parameter int DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        parity_err_o
);
  localparam int AW = $clog2(DEPTH);
`ifdef DATA_RAM_PARITY_EN
  localparam int W = 33;
`else
  localparam int W = 32;
`endif
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam logic [32:0] LIM = 33'(DEPTH) << 2;
  logic [W-1:0] mem [DEPTH];
  logic [0:0] state;
  logic [AW-1:0] clr_idx;
  logic [AW-1:0] idx;
  logic [32:0] diff;
  logic [W-1:0] wdata;
  logic valid;
  logic wr;
  // 33-bit difference: an address below BASE_ADDR borrows into bit 32 and fails the limit test
  assign diff = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign valid = diff < LIM && addr_i[1:0] == 2'b00;
  assign idx = diff[AW+1:2];
  assign busy_o = state == CLEAR;
  assign wr = reset && (busy_o || (valid && we_i));
`ifdef DATA_RAM_PARITY_EN
  assign wdata = busy_o ? '0 : {^data_i, data_i};
`else
  assign wdata = busy_o ? '0 : data_i;
`endif
  always_ff @(posedge clk)
    if (wr) mem[busy_o ? clr_idx : idx] <= wdata;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= CLEAR;
      clr_idx <= '0;
      data_o <= '0;
      err_o <= 1'b0;
    end else if (busy_o) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == AW'(DEPTH - 1)) state <= READY;
    end else begin
      err_o <= !valid;
      if (!valid) data_o <= '0;
      else if (!we_i) data_o <= mem[idx][31:0];
    end
`ifdef DATA_RAM_PARITY_EN
  always_ff @(posedge clk)
    parity_err_o <= reset && !busy_o && valid && !we_i && (^mem[idx]);
`else
  assign parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: scoreboard bench for two data_ram instances (BASE_ADDR 0 and 0x100, DEPTH 16)
module tb_data_ram;
  logic clk = 1'b0, reset = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, data = '0;
  logic [31:0] d0, d1;
  logic b0, b1, e0, e1, p0, p1;
  logic [69:0] got;
  data_ram #(.DEPTH(16), .BASE_ADDR(32'h0)) u0 (.clk(clk), .reset(reset), .we_i(we), .addr_i(addr), .data_i(data),
    .data_o(d0), .busy_o(b0), .err_o(e0), .parity_err_o(p0));
  data_ram #(.DEPTH(16), .BASE_ADDR(32'h100)) u1 (.clk(clk), .reset(reset), .we_i(we), .addr_i(addr), .data_i(data),
    .data_o(d1), .busy_o(b1), .err_o(e1), .parity_err_o(p1));
  always #5 clk = ~clk;
  assign got = {d0, d1, e1, e0, p1, p0, b0, b1};
  typedef struct packed {logic [1:0][31:0] d; logic [1:0] e, p; logic b;} exp_t;
  typedef struct packed {logic r, w; logic [31:0] a, d;} stim_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, clr = 0;
  logic [31:0] m [2][16];
  bit bad [2][16];
  logic [31:0] pd [2];
  longint base [2] = '{0, 256};
  function automatic logic [69:0] want(exp_t x);
    return {x.d[0], x.d[1], x.e, x.p, x.b, x.b};
  endfunction
  task automatic step(input logic r, w, input logic [31:0] a, dd);
    exp_t x;
    @(negedge clk);
    reset = r; we = w; addr = a; data = dd;
    x = '0;
    if (!r) begin
      clr = 16;
      x.b = 1'b1;
      for (int k = 0; k < 2; k++) begin
        pd[k] = '0;
        for (int j = 0; j < 16; j++) begin m[k][j] = '0; bad[k][j] = 0; end
      end
    end else if (clr > 0) begin
      clr--;
      x.b = clr > 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        longint la;
        bit v;
        int i;
        la = {32'b0, a};
        v = la >= base[k] && la < base[k] + 64 && a[1:0] == 2'b00;
        i = int'((la - base[k]) / 4);
        if (v && w) begin m[k][i] = dd; bad[k][i] = 0; end
        else if (v) pd[k] = m[k][i];
        else pd[k] = '0;
        x.d[k] = pd[k];
        x.e[k] = !v;
        x.p[k] = v && !w && bad[k][i];
      end
    end
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    exp_t x;
    int cnt;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      x = q.pop_front(); n_cmp++;
      if (got !== want(x)) begin n_bad++; $display("FAIL reset[%0d] got=%h want=%h", i, got, want(x)); end
    end
    cnt = int'(b0);
    for (int i = 0; i < 40 && b0; i++) begin
      step(1'b1, 1'b0, 32'h0, 32'h0);
      x = q.pop_front(); n_cmp++;
      if (got !== want(x)) begin n_bad++; $display("FAIL clear[%0d] got=%h want=%h", i, got, want(x)); end
      cnt += int'(b0);
    end
    n_cmp++;
    if (cnt !== 16) begin n_bad++; $display("FAIL busy_cycles got=%0d want=16", cnt); end
    step(1'b1, 1'b0, 32'h3C, 32'h0);
    x = q.pop_front(); n_cmp++;
    if (got !== want(x) || d0 !== 32'h0 || e0 !== 1'b0) begin n_bad++; $display("FAIL read_3c got=%h want=%h", got, want(x)); end
  endtask
  task automatic test_write_read();
    exp_t x;
    stim_t s [2] = '{'{1'b1, 1'b1, 32'h10, 32'hDEADBEEF}, '{1'b1, 1'b0, 32'h10, 32'h0}};
    for (int i = 0; i < 2; i++) begin
      step(s[i].r, s[i].w, s[i].a, s[i].d);
      x = q.pop_front(); n_cmp++;
      if (got !== want(x)) begin n_bad++; $display("FAIL write_read[%0d] got=%h want=%h", i, got, want(x)); end
    end
    n_cmp++;
    if (d0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL raw_data got=%h want=deadbeef", d0); end
  endtask
  task automatic test_misaligned();
    exp_t x;
    stim_t s [3] = '{'{1'b1, 1'b1, 32'h12, 32'h1}, '{1'b1, 1'b0, 32'h10, 32'h0}, '{1'b1, 1'b0, 32'h13, 32'h0}};
    for (int i = 0; i < 3; i++) begin
      step(s[i].r, s[i].w, s[i].a, s[i].d);
      x = q.pop_front(); n_cmp++;
      if (got !== want(x)) begin n_bad++; $display("FAIL misaligned[%0d] got=%h want=%h", i, got, want(x)); end
    end
  endtask
  task automatic test_range();
    exp_t x;
    stim_t s [6] = '{'{1'b1, 1'b0, 32'h140, 32'h0}, '{1'b1, 1'b0, 32'hFC, 32'h0}, '{1'b1, 1'b1, 32'h140, 32'h55},
                     '{1'b1, 1'b0, 32'h100, 32'h0}, '{1'b1, 1'b1, 32'h13C, 32'h77}, '{1'b1, 1'b0, 32'h13C, 32'h0}};
    for (int i = 0; i < 6; i++) begin
      step(s[i].r, s[i].w, s[i].a, s[i].d);
      x = q.pop_front(); n_cmp++;
      if (got !== want(x)) begin n_bad++; $display("FAIL range[%0d] got=%h want=%h", i, got, want(x)); end
    end
  endtask
  task automatic test_busy_reset();
    exp_t x;
    stim_t s[$];
    s.push_back('{1'b0, 1'b0, 32'h0, 32'h0});
    s.push_back('{1'b1, 1'b1, 32'h0, 32'h55});
    repeat (15) s.push_back('{1'b1, 1'b0, 32'h0, 32'h0});
    s.push_back('{1'b1, 1'b0, 32'h0, 32'h0});
    s.push_back('{1'b1, 1'b1, 32'h4, 32'hA5A5A5A5});
    s.push_back('{1'b0, 1'b1, 32'h8, 32'hA5A5A5A5});
    repeat (5) s.push_back('{1'b1, 1'b0, 32'h0, 32'h0});
    s.push_back('{1'b0, 1'b0, 32'h0, 32'h0});
    repeat (16) s.push_back('{1'b1, 1'b0, 32'h4, 32'h0});
    s.push_back('{1'b1, 1'b0, 32'h4, 32'h0});
    s.push_back('{1'b1, 1'b0, 32'h8, 32'h0});
    foreach (s[i]) begin
      step(s[i].r, s[i].w, s[i].a, s[i].d);
      x = q.pop_front(); n_cmp++;
      if (got !== want(x)) begin n_bad++; $display("FAIL busy_reset[%0d] got=%h want=%h", i, got, want(x)); end
    end
  endtask
  task automatic test_back_to_back();
    exp_t x;
    logic [31:0] a;
    int k;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      a = k < 4 ? 32'($urandom_range(0, 15) * 4) : k < 8 ? 32'(256 + $urandom_range(0, 15) * 4) :
          k == 8 ? 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3)) : $urandom;
      step(1'b1, 1'($urandom_range(0, 1)), a, $urandom);
      x = q.pop_front(); n_cmp++;
      if (got !== want(x)) begin n_bad++; $display("FAIL b2b[%0d] addr=%h got=%h want=%h", i, a, got, want(x)); end
    end
  endtask
`ifdef DATA_RAM_PARITY_EN
  task automatic test_parity();
    exp_t x;
    stim_t s [4] = '{'{1'b1, 1'b1, 32'h8, 32'h1}, '{1'b1, 1'b0, 32'h8, 32'h0}, '{1'b1, 1'b0, 32'h8, 32'h0},
                     '{1'b1, 1'b0, 32'hC, 32'h0}};
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin u0.mem[2][0] = ~u0.mem[2][0]; m[0][2] = 32'h0; bad[0][2] = 1; end
      step(s[i].r, s[i].w, s[i].a, s[i].d);
      x = q.pop_front(); n_cmp++;
      if (got !== want(x)) begin n_bad++; $display("FAIL parity[%0d] got=%h want=%h", i, got, want(x)); end
      if (i == 1) begin
        n_cmp++;
        if (d0 !== 32'h0 || p0 !== 1'b1) begin n_bad++; $display("FAIL parity_flag got d=%h p=%b want d=0 p=1", d0, p0); end
      end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_range();
    test_busy_reset();
    test_back_to_back();
`ifdef DATA_RAM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
Single-port, word-organised data/instruction RAM. It is the responder end of the control unit's memory bus (we/addr/write-data out, read-data in).
- Decodes byte addresses and performs writes.
- Returns registered read data one cycle after the address is presented.
- Flags misaligned and out-of-range accesses.
- Clears its contents with a sequencer after every reset.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, >= 2
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous active-low reset
we_i  input  1  1 = write access, 0 = read access (sampled every READY cycle)
addr_i  input  32  byte address from control unit
data_i  input  32  write data from control unit
data_o  output  32  registered read data to control unit
busy_o  output  1  1 while the clear sequencer runs; accesses ignored
err_o  output  1  1 for the cycle after an invalid access
parity_err_o  output  1  parity fault on last read (DATA_RAM_PARITY_EN only, else tied 0)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, port named reset.
- Reset (reset==0 at posedge) sets:
  - data_o=0, err_o=0, parity_err_o=0
  - busy_o=1, state=CLEAR, clr_idx=0
- While reset is held low, these values hold.
- States: CLEAR, READY.
- CLEAR:
  - Each posedge writes mem[clr_idx]=0 and increments clr_idx.
  - On the write of clr_idx==DEPTH-1, go to READY; busy_o=0 from that edge.
  - busy_o is therefore high for exactly DEPTH cycles after reset release.
  - we_i/addr_i/data_i are ignored; data_o and err_o stay 0.
- Address decode (READY):
  - off = addr_i - BASE_ADDR, 32-bit unsigned.
  - valid = (addr_i >= BASE_ADDR) && (off < 4*DEPTH) && (addr_i[1:0]==2'b00).
  - idx = off[log2(DEPTH)+1:2].
- READY, per posedge:
  - Valid write: mem[idx]<=data_i; data_o holds its previous value; err_o<=0.
  - Valid read: data_o<=mem[idx] (old contents); err_o<=0.
  - Invalid access: no memory update; data_o<=0; err_o<=1.
- Read latency:
  - Address presented before edge N, data on data_o after edge N.
  - The control unit latches it at the following edge.
  - Idle bus (we_i=0, addr_i=0) performs continuous reads of word 0. This is legal and has no side effects.
- Read-after-write to the same address on consecutive accesses returns the new data. No forwarding is needed because the port is single-access.
- err_o is level-per-access: it deasserts on the first valid access.
- Reset mid-CLEAR or mid-access: the in-flight write is discarded if reset is low at that edge, and CLEAR restarts from idx 0.
- No wrap-around of idx: out-of-range addresses error, they never alias.

Optional Feature:
Macro: DATA_RAM_PARITY_EN
- Defined:
  - Storage is 33 bits per word; bit 32 = ^data_i, written on every write.
  - CLEAR writes 33'b0, which has consistent parity.
  - On a valid read, parity_err_o<=(^stored[32:0]) != 0 for that cycle; data_o still returns stored[31:0].
  - parity_err_o<=0 on writes, invalid accesses and during CLEAR.
- Undefined: 32-bit storage, no parity logic; parity_err_o constant 0.

Test Plan:
- DEPTH=16, reset low 2 cycles then high -> busy_o=1 for 16 cycles then 0; read addr 0x3C -> data_o=0, err_o=0.
- Write 0xDEADBEEF @0x10, next cycle read 0x10 -> data_o holds prior value after the write edge; 0xDEADBEEF after the read edge; err_o=0.
- Write 0x00000001 @0x12 (misaligned) -> err_o=1 next cycle; following read 0x10 -> 0xDEADBEEF, err_o=0.
- BASE_ADDR=0x100, DEPTH=16: read 0x140 and 0xFC -> data_o=0, err_o=1 each; write 0x55 @0x140 is ignored, and a read of 0x100 returns 0.
- Write 0x55 @0x0 while busy_o=1 -> ignored; after CLEAR, read 0x0 -> 0. Write 0xA5A5A5A5 @0x4, drop reset 1 cycle mid-stream -> data_o=0, busy_o=1 for DEPTH cycles, read 0x4 -> 0.
- With DATA_RAM_PARITY_EN: write 0x1 @0x8, flip stored bit 0 by hierarchical access, read 0x8 -> data_o=0x0, parity_err_o=1 for one cycle. Without the macro -> parity_err_o=0 throughout.
